// File: rtl/spi_bram_bridge.sv
// spi_bram_bridge
//   SPI slave (mode 0, MSB first) that gives an external MCU burst read/write
//   access to one BRAM port. Frame = cs low: command byte, ADDR_BYTES address
//   bytes, then data words. 0x02 = write burst, 0x0B = read burst (DUMMY_BYTES
//   turnaround bytes first). The address auto-increments and wraps modulo
//   2**ADDR_W. Any other command pulses err_out and the rest of the frame is
//   ignored.
//
// Ports
//   sys_clk_100_in  system clock (sclk_in at most sys_clk_100_in/8)
//   sys_rst_n_in    asynchronous active-low reset
//   sclk_in         SPI clock (asynchronous)
//   mosi_in         SPI data in (asynchronous)
//   cs_in           SPI chip select, active low (asynchronous)
//   miso_out        SPI data out, 0 whenever cs_in is high
//   bram_en_out     BRAM enable, one-clock pulse per access
//   bram_wen_out    BRAM write enable, only together with bram_en_out
//   bram_addr_out   BRAM address
//   bram_wdata_out  BRAM write data
//   bram_rdata_in   BRAM read data, RD_LATENCY clocks after bram_en_out
//   busy_out        high while a frame is in progress
//   err_out         one-clock pulse on an unknown command byte
module spi_bram_bridge #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int ADDR_BYTES  = 2,
  parameter int DUMMY_BYTES = 1,
  parameter int RD_LATENCY  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk_100_in,
  input  logic              sys_rst_n_in,
  input  logic              sclk_in,
  input  logic              mosi_in,
  input  logic              cs_in,
  output logic              miso_out,
  output logic              bram_en_out,
  output logic              bram_wen_out,
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic [DATA_W-1:0] bram_wdata_out,
  input  logic [DATA_W-1:0] bram_rdata_in,
  output logic              busy_out,
  output logic              err_out
);

  localparam int ADDR_BITS  = 8 * ADDR_BYTES;
  localparam int DUMMY_BITS = 8 * DUMMY_BYTES;
  localparam int RX_W0      = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int RX_W       = (RX_W0 > 8) ? RX_W0 : 8;
  localparam int CNT_MAX0   = (ADDR_BITS > DATA_W) ? ADDR_BITS : DATA_W;
  localparam int CNT_MAX    = (CNT_MAX0 > DUMMY_BITS) ? CNT_MAX0 : DUMMY_BITS;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_CMD_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST  = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_WORD_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_WORD_DONE  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_DUMMY_DONE = CNT_W'(DUMMY_BITS);

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DUMMY  = 3'd4;
  localparam logic [2:0] S_READ   = 3'd5;
  localparam logic [2:0] S_IGNORE = 3'd6;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic                   w_mosi;

  logic [2:0]             r_state;
  logic                   r_cmd_rd;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [RX_W-2:0]        r_rx;
  logic [RX_W-1:0]        w_rx_next;
  logic [ADDR_W-1:0]      w_addr_new;
  logic [7:0]             w_cmd;
  logic [DATA_W-1:0]      r_tx;
  logic [DATA_W-1:0]      r_prefetch;
  logic [ADDR_W-1:0]      r_addr;
  logic [RD_LATENCY:0]    r_rd_vld;
  logic                   w_boundary;

  // Stage 0: synchronisers. The cs chain clears to "low" so that a reset taken
  // mid-frame cannot fake a falling edge; a fresh cs high->low is required.
  always_ff @(posedge sys_clk_100_in or negedge sys_rst_n_in) begin
    if (!sys_rst_n_in) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_in};
    end
  end

  assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
  assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-2] & r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_rise   = r_cs_sync[SYNC_STAGES-2] & ~r_cs_sync[SYNC_STAGES-1];
  assign w_cs_fall   = ~r_cs_sync[SYNC_STAGES-2] & r_cs_sync[SYNC_STAGES-1];
  // MOSI only changes on sclk fall, so the fully delayed copy is stable at rise.
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];

  assign w_rx_next  = {r_rx, w_mosi};
  assign w_addr_new = w_rx_next[ADDR_W-1:0];
  assign w_cmd      = w_rx_next[7:0];

  // Word boundary on the read side: falling edge after the last dummy bit or
  // after the last bit of a read word.
  assign w_boundary = w_sclk_fall &&
                      (((r_state == S_DUMMY) && (r_bit_cnt == CNT_DUMMY_DONE)) ||
                       ((r_state == S_READ)  && (r_bit_cnt == CNT_WORD_DONE)));

  // Stage 1: frame FSM, BRAM access issue and read prefetch.
  always_ff @(posedge sys_clk_100_in or negedge sys_rst_n_in) begin
    if (!sys_rst_n_in) begin
      r_state        <= S_IDLE;
      r_cmd_rd       <= 1'b0;
      r_bit_cnt      <= '0;
      r_rx           <= '0;
      r_tx           <= '0;
      r_prefetch     <= '0;
      r_addr         <= '0;
      r_rd_vld       <= '0;
      bram_en_out    <= 1'b0;
      bram_wen_out   <= 1'b0;
      bram_addr_out  <= '0;
      bram_wdata_out <= '0;
      err_out        <= 1'b0;
    end else begin
      bram_en_out  <= 1'b0;
      bram_wen_out <= 1'b0;
      err_out      <= 1'b0;
      r_rd_vld     <= r_rd_vld << 1;
      if (r_rd_vld[RD_LATENCY]) r_prefetch <= bram_rdata_in;

      // cs rise has priority over any sclk edge seen in the same cycle.
      if (w_cs_rise) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= '0;
        r_rd_vld  <= '0;
        r_tx      <= '0;
      end else if (w_cs_fall) begin
        r_state   <= S_CMD;
        r_bit_cnt <= '0;
      end else if (w_sclk_rise) begin
        case (r_state)
          S_CMD: begin
            r_rx <= w_rx_next[RX_W-2:0];
            if (r_bit_cnt == CNT_CMD_LAST) begin
              r_bit_cnt <= '0;
              if (w_cmd == CMD_WRITE) begin
                r_cmd_rd <= 1'b0;
                r_state  <= S_ADDR;
              end else if (w_cmd == CMD_READ) begin
                r_cmd_rd <= 1'b1;
                r_state  <= S_ADDR;
              end else begin
                err_out <= 1'b1;
                r_state <= S_IGNORE;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          S_ADDR: begin
            r_rx <= w_rx_next[RX_W-2:0];
            if (r_bit_cnt == CNT_ADDR_LAST) begin
              r_bit_cnt <= '0;
              if (r_cmd_rd) begin
                // First prefetch goes out as soon as the address is known.
                r_state       <= S_DUMMY;
                bram_en_out   <= 1'b1;
                bram_addr_out <= w_addr_new;
                r_addr        <= w_addr_new + 1'b1;
                r_rd_vld[0]   <= 1'b1;
              end else begin
                r_state <= S_WRITE;
                r_addr  <= w_addr_new;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          S_WRITE: begin
            r_rx <= w_rx_next[RX_W-2:0];
            if (r_bit_cnt == CNT_WORD_LAST) begin
              r_bit_cnt      <= '0;
              bram_en_out    <= 1'b1;
              bram_wen_out   <= 1'b1;
              bram_addr_out  <= r_addr;
              bram_wdata_out <= w_rx_next[DATA_W-1:0];
              r_addr         <= r_addr + 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          S_DUMMY, S_READ: r_bit_cnt <= r_bit_cnt + 1'b1;
          default: ;
        endcase
      end else if (w_boundary) begin
        r_state       <= S_READ;
        r_bit_cnt     <= '0;
        r_tx          <= r_prefetch;
        bram_en_out   <= 1'b1;
        bram_addr_out <= r_addr;
        r_addr        <= r_addr + 1'b1;
        r_rd_vld[0]   <= 1'b1;
      end else if (w_sclk_fall && (r_state == S_READ)) begin
        r_tx <= {r_tx[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Raw cs_in gating keeps MISO quiet the moment the master deselects.
  assign miso_out = (r_state == S_READ) & ~cs_in & r_tx[DATA_W-1];
  assign busy_out = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_bram_bridge.sv
// tb_spi_bram_bridge
//   Directed bench for spi_bram_bridge: an 8-bit instance (default parameters)
//   and a 16-bit / latency-3 instance share sclk/mosi but have their own cs.
//   Each instance is backed by a small BRAM model with the instance's read
//   latency; BRAM accesses and err pulses are logged on the falling clock edge.
module tb_spi_bram_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic sclk = 1'b0, mosi = 1'b0, cs8 = 1'b1, cs16 = 1'b1;
  logic sel = 1'b0;

  logic        miso8, en8, wen8, busy8, err8;
  logic [12:0] addr8;
  logic [7:0]  wd8, rd8;
  logic        miso16, en16, wen16, busy16, err16;
  logic [12:0] addr16;
  logic [15:0] wd16, rd16;

  spi_bram_bridge u_dut8 (
    .sys_clk_100_in(clk), .sys_rst_n_in(rst_n), .sclk_in(sclk), .mosi_in(mosi),
    .cs_in(cs8), .miso_out(miso8), .bram_en_out(en8), .bram_wen_out(wen8),
    .bram_addr_out(addr8), .bram_wdata_out(wd8), .bram_rdata_in(rd8),
    .busy_out(busy8), .err_out(err8)
  );

  spi_bram_bridge #(.DATA_W(16), .RD_LATENCY(3)) u_dut16 (
    .sys_clk_100_in(clk), .sys_rst_n_in(rst_n), .sclk_in(sclk), .mosi_in(mosi),
    .cs_in(cs16), .miso_out(miso16), .bram_en_out(en16), .bram_wen_out(wen16),
    .bram_addr_out(addr16), .bram_wdata_out(wd16), .bram_rdata_in(rd16),
    .busy_out(busy16), .err_out(err16)
  );

  // BRAM models: data appears RD_LATENCY clocks after the enable is sampled;
  // idle pipeline slots carry zero so a mistimed capture shows up.
  logic [7:0]  mem8  [0:8191];
  logic [15:0] mem16 [0:8191];
  logic [7:0]  p8  [0:1];
  logic [15:0] p16 [0:2];

  always @(posedge clk) begin
    if (en8 && wen8) mem8[addr8] <= wd8;
    p8[0] <= (en8 && !wen8) ? mem8[addr8] : 8'h00;
    p8[1] <= p8[0];
    if (en16 && wen16) mem16[addr16] <= wd16;
    p16[0] <= (en16 && !wen16) ? mem16[addr16] : 16'h0000;
    p16[1] <= p16[0];
    p16[2] <= p16[1];
  end
  assign rd8  = p8[1];
  assign rd16 = p16[2];

  logic [12:0] la8[$];
  logic        lw8[$];
  logic [7:0]  ld8[$];
  logic [12:0] la16[$];
  logic        lw16[$];
  logic [15:0] ld16[$];
  int err_cnt8 = 0, orphan8 = 0, miso8_hi = 0;

  always @(negedge clk) begin
    if (en8) begin la8.push_back(addr8); lw8.push_back(wen8); ld8.push_back(wd8); end
    if (en16) begin la16.push_back(addr16); lw16.push_back(wen16); ld16.push_back(wd16); end
    if (wen8 && !en8) orphan8++;
    if (err8) err_cnt8++;
    if (miso8) miso8_hi++;
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] txb [0:7];
  logic [7:0] rxb [0:7];
  logic busy_mid;

  task automatic clear_logs();
    la8.delete(); lw8.delete(); ld8.delete();
    la16.delete(); lw16.delete(); ld16.delete();
    err_cnt8 = 0; orphan8 = 0; miso8_hi = 0;
  endtask

  task automatic spi_byte(input logic [7:0] b, input int nb, output logic [7:0] r);
    r = '0;
    for (int i = 7; i >= 8 - nb; i--) begin
      mosi = b[i];
      #80;
      r[i] = sel ? miso16 : miso8;
      sclk = 1'b1;
      #80;
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input int n, input int last_bits);
    if (sel) cs16 = 1'b0; else cs8 = 1'b0;
    #160;
    busy_mid = sel ? busy16 : busy8;
    for (int k = 0; k < n; k++) spi_byte(txb[k], (k == n - 1) ? last_bits : 8, rxb[k]);
    #80;
    cs8 = 1'b1; cs16 = 1'b1; mosi = 1'b0;
    #320;
  endtask

  task automatic test_reset();
    #30;
    checks++; if (miso8 !== 1'b0) begin errors++; $display("FAIL rst_miso: got %b expected 0", miso8); end
    checks++; if (en8 !== 1'b0 || wen8 !== 1'b0) begin errors++; $display("FAIL rst_en: got en=%b wen=%b expected 0", en8, wen8); end
    checks++; if (addr8 !== 13'h0 || wd8 !== 8'h0) begin errors++; $display("FAIL rst_bus: got addr=%h wdata=%h expected 0", addr8, wd8); end
    checks++; if (busy8 !== 1'b0 || err8 !== 1'b0) begin errors++; $display("FAIL rst_flags: got busy=%b err=%b expected 0", busy8, err8); end
    rst_n = 1'b1;
    #40;
  endtask

  task automatic test_write_wrap();
    logic [12:0] ea [0:2];
    logic [7:0]  ed [0:2];
    ea = '{13'h1FFE, 13'h1FFF, 13'h0000};
    ed = '{8'hAA, 8'hBB, 8'hCC};
    clear_logs();
    txb[0] = 8'h02; txb[1] = 8'h1F; txb[2] = 8'hFE; txb[3] = 8'hAA; txb[4] = 8'hBB; txb[5] = 8'hCC;
    run_frame(6, 8);
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL wr_busy_mid: got %b expected 1", busy_mid); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL wr_busy_end: got %b expected 0", busy8); end
    checks++; if (la8.size() !== 3) begin errors++; $display("FAIL wr_count: got %0d expected 3", la8.size()); end
    for (int i = 0; i < 3 && i < la8.size(); i++) begin
      checks++; if (la8[i] !== ea[i] || ld8[i] !== ed[i] || lw8[i] !== 1'b1) begin
        errors++; $display("FAIL wr_access%0d: got addr=%h data=%h wen=%b expected addr=%h data=%h wen=1", i, la8[i], ld8[i], lw8[i], ea[i], ed[i]);
      end
    end
    checks++; if (orphan8 !== 0 || err_cnt8 !== 0) begin errors++; $display("FAIL wr_side: got orphan_wen=%0d err=%0d expected 0 0", orphan8, err_cnt8); end
  endtask

  task automatic test_read_wrap();
    logic [12:0] ea [0:2];
    int nw;
    ea = '{13'h1FFE, 13'h1FFF, 13'h0000};
    clear_logs();
    txb[0] = 8'h0B; txb[1] = 8'h1F; txb[2] = 8'hFE;
    for (int i = 3; i < 7; i++) txb[i] = 8'h00;
    run_frame(7, 8);
    checks++; if (rxb[3] !== 8'h00) begin errors++; $display("FAIL rd_dummy_miso: got %h expected 00", rxb[3]); end
    checks++; if ({rxb[4], rxb[5], rxb[6]} !== 24'hAABBCC) begin errors++; $display("FAIL rd_data: got %h%h%h expected AABBCC", rxb[4], rxb[5], rxb[6]); end
    checks++; if (la8.size() < 3) begin errors++; $display("FAIL rd_count: got %0d expected at least 3", la8.size()); end
    for (int i = 0; i < 3 && i < la8.size(); i++) begin
      checks++; if (la8[i] !== ea[i]) begin errors++; $display("FAIL rd_addr%0d: got %h expected %h", i, la8[i], ea[i]); end
    end
    nw = 0;
    foreach (lw8[i]) if (lw8[i]) nw++;
    checks++; if (nw !== 0 || orphan8 !== 0) begin errors++; $display("FAIL rd_no_wen: got wen=%0d orphan=%0d expected 0 0", nw, orphan8); end
  endtask

  task automatic test_partial();
    clear_logs();
    txb[0] = 8'h02; txb[1] = 8'h00; txb[2] = 8'h10; txb[3] = 8'h55; txb[4] = 8'hFF;
    run_frame(5, 5);
    checks++; if (la8.size() !== 1) begin errors++; $display("FAIL part_count: got %0d expected 1", la8.size()); end
    if (la8.size() > 0) begin
      checks++; if (la8[0] !== 13'h0010 || ld8[0] !== 8'h55 || lw8[0] !== 1'b1) begin
        errors++; $display("FAIL part_write: got addr=%h data=%h wen=%b expected 0010 55 1", la8[0], ld8[0], lw8[0]);
      end
    end
    checks++; if (busy8 !== 1'b0 || err_cnt8 !== 0) begin errors++; $display("FAIL part_idle: got busy=%b err=%0d expected 0 0", busy8, err_cnt8); end
  endtask

  task automatic test_bad_cmd();
    clear_logs();
    txb[0] = 8'h9F; txb[1] = 8'h12; txb[2] = 8'h34; txb[3] = 8'h56;
    run_frame(4, 8);
    checks++; if (err_cnt8 !== 1) begin errors++; $display("FAIL bad_err_pulse: got %0d cycles expected 1", err_cnt8); end
    checks++; if (la8.size() !== 0) begin errors++; $display("FAIL bad_no_bram: got %0d accesses expected 0", la8.size()); end
    checks++; if (miso8_hi !== 0) begin errors++; $display("FAIL bad_miso: got %0d high cycles expected 0", miso8_hi); end
    txb[0] = 8'h02; txb[1] = 8'h00; txb[2] = 8'h20; txb[3] = 8'h77;
    run_frame(4, 8);
    checks++; if (la8.size() !== 1) begin errors++; $display("FAIL bad_next_count: got %0d expected 1", la8.size()); end
    if (la8.size() > 0) begin
      checks++; if (la8[0] !== 13'h0020 || ld8[0] !== 8'h77) begin errors++; $display("FAIL bad_next_write: got addr=%h data=%h expected 0020 77", la8[0], ld8[0]); end
    end
    checks++; if (err_cnt8 !== 1) begin errors++; $display("FAIL bad_next_err: got %0d expected 1", err_cnt8); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] dummy;
    clear_logs();
    cs8 = 1'b0;
    #160;
    spi_byte(8'h02, 8, dummy);
    spi_byte(8'h00, 8, dummy);
    spi_byte(8'h30, 8, dummy);
    spi_byte(8'h11, 8, dummy);
    spi_byte(8'h22, 4, dummy);
    rst_n = 1'b0;
    #1;
    checks++; if (en8 !== 1'b0 || wen8 !== 1'b0) begin errors++; $display("FAIL rmid_en: got en=%b wen=%b expected 0", en8, wen8); end
    checks++; if (addr8 !== 13'h0 || wd8 !== 8'h0) begin errors++; $display("FAIL rmid_bus: got addr=%h wdata=%h expected 0", addr8, wd8); end
    checks++; if (busy8 !== 1'b0 || err8 !== 1'b0 || miso8 !== 1'b0) begin errors++; $display("FAIL rmid_flags: got busy=%b err=%b miso=%b expected 0", busy8, err8, miso8); end
    #9;
    rst_n = 1'b1;
    #40;
    spi_byte(8'h02, 8, dummy);
    spi_byte(8'hFF, 8, dummy);
    checks++; if (busy8 !== 1'b0 || la8.size() !== 1) begin errors++; $display("FAIL rmid_no_frame: got busy=%b accesses=%0d expected 0 1", busy8, la8.size()); end
    cs8 = 1'b1;
    #320;
    txb[0] = 8'h02; txb[1] = 8'h00; txb[2] = 8'h40; txb[3] = 8'h66;
    run_frame(4, 8);
    checks++; if (la8.size() !== 2) begin errors++; $display("FAIL rmid_next_count: got %0d expected 2", la8.size()); end
    if (la8.size() > 1) begin
      checks++; if (la8[0] !== 13'h0030 || ld8[0] !== 8'h11) begin errors++; $display("FAIL rmid_before: got addr=%h data=%h expected 0030 11", la8[0], ld8[0]); end
      checks++; if (la8[1] !== 13'h0040 || ld8[1] !== 8'h66 || lw8[1] !== 1'b1) begin errors++; $display("FAIL rmid_next_write: got addr=%h data=%h wen=%b expected 0040 66 1", la8[1], ld8[1], lw8[1]); end
    end
  endtask

  task automatic test_wide();
    clear_logs();
    sel = 1'b1;
    txb[0] = 8'h02; txb[1] = 8'h00; txb[2] = 8'h00; txb[3] = 8'h12; txb[4] = 8'h34;
    run_frame(5, 8);
    txb[0] = 8'h0B; txb[1] = 8'h00; txb[2] = 8'h00; txb[3] = 8'h00; txb[4] = 8'h00; txb[5] = 8'h00;
    run_frame(6, 8);
    sel = 1'b0;
    checks++; if (la16.size() < 2) begin errors++; $display("FAIL w16_count: got %0d expected at least 2", la16.size()); end
    if (la16.size() > 1) begin
      checks++; if (la16[0] !== 13'h0 || ld16[0] !== 16'h1234 || lw16[0] !== 1'b1) begin errors++; $display("FAIL w16_write: got addr=%h data=%h wen=%b expected 0000 1234 1", la16[0], ld16[0], lw16[0]); end
      checks++; if (la16[1] !== 13'h0 || lw16[1] !== 1'b0) begin errors++; $display("FAIL w16_read_issue: got addr=%h wen=%b expected 0000 0", la16[1], lw16[1]); end
    end
    checks++; if ({rxb[4], rxb[5]} !== 16'h1234) begin errors++; $display("FAIL w16_readback: got %h%h expected 1234", rxb[4], rxb[5]); end
  endtask

  initial begin
    test_reset();
    test_write_wrap();
    test_read_wrap();
    test_partial();
    test_bad_cmd();
    test_reset_mid();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
